// File: rtl/glitc_i2c_pkg.sv
// Shared state encoding and byte-framing constants for the GLITC I2C target.
package glitc_i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ACK_ADDR,
        WR_PTR,
        WR_DATA,
        RD_BYTE,
        RD_ACK
    } i2c_state_t;

    localparam int I2C_BYTE_BITS = 8;
    localparam int I2C_RW_BIT    = 0;

endpackage

// File: rtl/i2c_line_cond.sv
// Conditions one I2C pad input: synchronizer, optional stability filter
// (GLITC_I2C_TARGET_GLITCH_FILTER_EN) and single-cycle rise/fall detection.
module i2c_line_cond #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   cond;
    logic                   prev_reg;

    // Idle bus level is high, so the chain resets to 1 to avoid a false edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '1;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], line};
        end
    end

`ifdef GLITC_I2C_TARGET_GLITCH_FILTER_EN
    logic [1:0] hist_reg;
    logic       filt_reg;
    logic       sync_out;

    assign sync_out = sync_reg[SYNC_STAGES-1];
    // Follow the input only once three consecutive samples agree.
    assign cond = (sync_out == hist_reg[0] && sync_out == hist_reg[1]) ? sync_out : filt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_reg <= 2'b11;
            filt_reg <= 1'b1;
        end else begin
            hist_reg <= {hist_reg[0], sync_out};
            filt_reg <= cond;
        end
    end
`else
    assign cond = sync_reg[SYNC_STAGES-1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_reg <= 1'b1;
        end else begin
            prev_reg <= cond;
        end
    end

    assign level = cond;
    assign rise  = cond & ~prev_reg;
    assign fall  = ~cond & prev_reg;

endmodule

// File: rtl/glitc_i2c_target.sv
// I2C register-bank target with auto-incrementing pointer and write strobe.
// Define GLITC_I2C_TARGET_GLITCH_FILTER_EN to add a 3-sample filter on SCL/SDA.
module glitc_i2c_target
    import glitc_i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = 7'h60,
    parameter int         NUM_REGS    = 16,
    parameter int         PTR_W       = 4,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                  user_clk_i,
    input  logic                  user_rst_n_i,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  sda_o,
    output logic                  sda_oen_o,
    output logic [8*NUM_REGS-1:0] regs_o,
    output logic                  wr_stb_o,
    output logic [PTR_W-1:0]      wr_addr_o,
    output logic [7:0]            wr_dat_o,
    output logic                  busy_o
);

    localparam logic [3:0] BYTE_CNT = 4'(I2C_BYTE_BITS);

    logic scl_level, scl_rise, scl_fall;
    logic sda_level, sda_rise, sda_fall;
    logic start_cond, stop_cond;

    i2c_line_cond #(.SYNC_STAGES(SYNC_STAGES)) u_scl (
        .clk(user_clk_i), .rst_n(user_rst_n_i), .line(scl_i),
        .level(scl_level), .rise(scl_rise), .fall(scl_fall)
    );

    i2c_line_cond #(.SYNC_STAGES(SYNC_STAGES)) u_sda (
        .clk(user_clk_i), .rst_n(user_rst_n_i), .line(sda_i),
        .level(sda_level), .rise(sda_rise), .fall(sda_fall)
    );

    assign start_cond = sda_fall & scl_level;
    assign stop_cond  = sda_rise & scl_level;

    i2c_state_t       state_reg, state_next;
    logic [3:0]       bit_cnt_reg, bit_cnt_next;
    logic [7:0]       shift_reg, shift_next;
    logic [PTR_W-1:0] ptr_reg, ptr_next, ptr_inc;
    logic             rw_reg, rw_next;
    logic             ack_reg, ack_next;
    logic             sda_oen_reg, sda_oen_next;
    logic             busy_reg, busy_next;
    logic             wr_stb_reg, wr_stb_next;
    logic [PTR_W-1:0] wr_addr_reg, wr_addr_next;
    logic [7:0]       wr_dat_reg, wr_dat_next;
    logic             reg_we;
    logic [7:0]       regs_reg [NUM_REGS];

    assign ptr_inc = ptr_reg + PTR_W'(1);

    always_ff @(posedge user_clk_i or negedge user_rst_n_i) begin
        if (!user_rst_n_i) begin
            state_reg   <= IDLE;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            ptr_reg     <= '0;
            rw_reg      <= 1'b0;
            ack_reg     <= 1'b0;
            sda_oen_reg <= 1'b1;
            busy_reg    <= 1'b0;
            wr_stb_reg  <= 1'b0;
            wr_addr_reg <= '0;
            wr_dat_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
            ptr_reg     <= ptr_next;
            rw_reg      <= rw_next;
            ack_reg     <= ack_next;
            sda_oen_reg <= sda_oen_next;
            busy_reg    <= busy_next;
            wr_stb_reg  <= wr_stb_next;
            wr_addr_reg <= wr_addr_next;
            wr_dat_reg  <= wr_dat_next;
        end
    end

    always_ff @(posedge user_clk_i or negedge user_rst_n_i) begin
        if (!user_rst_n_i) begin
            for (int i = 0; i < NUM_REGS; i++) regs_reg[i] <= '0;
        end else if (reg_we) begin
            regs_reg[ptr_reg] <= shift_reg;
        end
    end

    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        ptr_next     = ptr_reg;
        rw_next      = rw_reg;
        ack_next     = ack_reg;
        sda_oen_next = sda_oen_reg;
        busy_next    = busy_reg;
        wr_stb_next  = 1'b0;
        wr_addr_next = wr_addr_reg;
        wr_dat_next  = wr_dat_reg;
        reg_we       = 1'b0;

        if (stop_cond) begin
            state_next   = IDLE;
            bit_cnt_next = '0;
            ack_next     = 1'b0;
            sda_oen_next = 1'b1;
            busy_next    = 1'b0;
        end else if (start_cond) begin
            state_next   = ADDR;
            bit_cnt_next = '0;
            ack_next     = 1'b0;
            sda_oen_next = 1'b1;
            busy_next    = 1'b0;
        end else begin
            case (state_reg)
                ADDR, WR_PTR, WR_DATA: begin
                    if (!ack_reg) begin
                        if (scl_rise && bit_cnt_reg < BYTE_CNT) begin
                            shift_next   = {shift_reg[6:0], sda_level};
                            bit_cnt_next = bit_cnt_reg + 4'd1;
                        end else if (scl_fall && bit_cnt_reg == BYTE_CNT) begin
                            bit_cnt_next = '0;
                            if (state_reg == ADDR) begin
                                if (shift_reg[7:1] == DEV_ADDR) begin
                                    state_next   = ACK_ADDR;
                                    rw_next      = shift_reg[I2C_RW_BIT];
                                    sda_oen_next = 1'b0;
                                    busy_next    = 1'b1;
                                end else begin
                                    state_next = IDLE;
                                end
                            end else begin
                                ack_next     = 1'b1;
                                sda_oen_next = 1'b0;
                                if (state_reg == WR_PTR) ptr_next = shift_reg[PTR_W-1:0];
                            end
                        end
                    end else if (scl_fall) begin
                        // End of the ACK clock: the byte is now final.
                        ack_next     = 1'b0;
                        sda_oen_next = 1'b1;
                        bit_cnt_next = '0;
                        if (state_reg == WR_PTR) begin
                            state_next = WR_DATA;
                        end else begin
                            reg_we       = 1'b1;
                            wr_stb_next  = 1'b1;
                            wr_addr_next = ptr_reg;
                            wr_dat_next  = shift_reg;
                            ptr_next     = ptr_inc;
                        end
                    end
                end
                ACK_ADDR: begin
                    if (scl_fall) begin
                        if (!rw_reg) begin
                            state_next   = WR_PTR;
                            sda_oen_next = 1'b1;
                            bit_cnt_next = '0;
                        end else begin
                            state_next   = RD_BYTE;
                            shift_next   = regs_reg[ptr_reg];
                            sda_oen_next = regs_reg[ptr_reg][7];
                            bit_cnt_next = 4'd1;
                        end
                    end
                end
                RD_BYTE: begin
                    if (scl_fall) begin
                        if (bit_cnt_reg == BYTE_CNT) begin
                            state_next   = RD_ACK;
                            sda_oen_next = 1'b1;
                        end else if (bit_cnt_reg == 4'd0) begin
                            sda_oen_next = shift_reg[7];
                            bit_cnt_next = 4'd1;
                        end else begin
                            shift_next   = {shift_reg[6:0], 1'b0};
                            sda_oen_next = shift_reg[6];
                            bit_cnt_next = bit_cnt_reg + 4'd1;
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        if (!sda_level) begin
                            state_next   = RD_BYTE;
                            ptr_next     = ptr_inc;
                            shift_next   = regs_reg[ptr_inc];
                            bit_cnt_next = '0;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_regs_out
            assign regs_o[8*gi +: 8] = regs_reg[gi];
        end
    endgenerate

    assign sda_o     = 1'b0;
    assign sda_oen_o = sda_oen_reg;
    assign wr_stb_o  = wr_stb_reg;
    assign wr_addr_o = wr_addr_reg;
    assign wr_dat_o  = wr_dat_reg;
    assign busy_o    = busy_reg;

endmodule

// File: tb/tb_glitc_i2c_target.sv
// Self-checking bench for glitc_i2c_target: bit-banged I2C master plus register-file model.
module tb_glitc_i2c_target;

    localparam int Q = 6;  // clocks per quarter SCL period

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         scl = 1'b1;
    logic         sda_m = 1'b1;
    logic         sda_o, sda_oen, wr_stb, busy;
    logic [127:0] regs_flat;
    logic [3:0]   wr_addr;
    logic [7:0]   wr_dat;
    wire          sda_bus = sda_m & (sda_oen | sda_o);

    int           vectors = 0;
    int           miscompares = 0;
    logic [7:0]   model_regs [16];
    logic [3:0]   model_ptr;
    logic [11:0]  got_q [$];
    logic [11:0]  exp_q [$];
    logic [7:0]   wr_buf [4];
    logic [7:0]   rd_got [4];
    logic [7:0]   rd_exp [4];

    glitc_i2c_target #(
        .DEV_ADDR(7'h60), .NUM_REGS(16), .PTR_W(4), .SYNC_STAGES(2)
    ) dut (
        .user_clk_i(clk), .user_rst_n_i(rst_n), .scl_i(scl), .sda_i(sda_bus),
        .sda_o(sda_o), .sda_oen_o(sda_oen), .regs_o(regs_flat), .wr_stb_o(wr_stb),
        .wr_addr_o(wr_addr), .wr_dat_o(wr_dat), .busy_o(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rst_n && wr_stb) got_q.push_back({wr_addr, wr_dat});

    initial begin
        #900000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [127:0] model_flat();
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = model_regs[i];
        return r;
    endfunction

    task automatic wq();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wq(); scl = 1'b1; wq(); sda_m = 1'b0; wq(); scl = 1'b0; wq();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wq(); scl = 1'b1; wq(); sda_m = 1'b1; wq(); wq();
    endtask

    task automatic wr_byte(input logic [7:0] d, input int glitch_bit, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            sda_m = d[i]; wq(); scl = 1'b1;
            if (i == glitch_bit) begin
                repeat (2) @(negedge clk);
                sda_m = ~d[i];
                @(negedge clk);
                sda_m = d[i];
                repeat (Q - 3) @(negedge clk);
            end else begin
                wq();
            end
            wq(); scl = 1'b0; wq();
        end
        sda_m = 1'b1; wq(); scl = 1'b1; wq(); ack = sda_bus; wq(); scl = 1'b0; wq();
    endtask

    task automatic rd_byte(input logic nack, output logic [7:0] d);
        for (int i = 7; i >= 0; i--) begin
            sda_m = 1'b1; wq(); scl = 1'b1; wq(); d[i] = sda_bus; wq(); scl = 1'b0; wq();
        end
        sda_m = nack; wq(); scl = 1'b1; wq(); wq(); scl = 1'b0; wq(); sda_m = 1'b1;
    endtask

    task automatic do_write(input logic [7:0] p, input int n, output logic ok);
        logic a;
        ok = 1'b1;
        i2c_start();
        wr_byte(8'hC0, -1, a); ok = ok & ~a;
        wr_byte(p, -1, a);     ok = ok & ~a;
        model_ptr = p[3:0];
        for (int k = 0; k < n; k++) begin
            wr_byte(wr_buf[k], -1, a); ok = ok & ~a;
            model_regs[model_ptr] = wr_buf[k];
            exp_q.push_back({model_ptr, wr_buf[k]});
            model_ptr = model_ptr + 4'd1;
        end
        i2c_stop();
    endtask

    task automatic do_read(input logic set_ptr, input logic [7:0] p, input int n, output logic ok);
        logic a;
        ok = 1'b1;
        i2c_start();
        if (set_ptr) begin
            wr_byte(8'hC0, -1, a); ok = ok & ~a;
            wr_byte(p, -1, a);     ok = ok & ~a;
            model_ptr = p[3:0];
            i2c_start();
        end
        wr_byte(8'hC1, -1, a); ok = ok & ~a;
        for (int k = 0; k < n; k++) begin
            rd_exp[k] = model_regs[model_ptr];
            rd_byte(k == n - 1, rd_got[k]);
            if (k < n - 1) model_ptr = model_ptr + 4'd1;
        end
        i2c_stop();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vectors++; if (sda_oen !== 1'b1) begin miscompares++; $display("FAIL reset_sda_oen got %b exp 1", sda_oen); end
        vectors++; if (wr_stb !== 1'b0) begin miscompares++; $display("FAIL reset_wr_stb got %b exp 0", wr_stb); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b exp 0", busy); end
        vectors++; if (regs_flat !== 128'd0) begin miscompares++; $display("FAIL reset_regs got %h exp 0", regs_flat); end
        vectors++; if ({wr_addr, wr_dat} !== 12'd0) begin miscompares++; $display("FAIL reset_wr_bus got %h exp 0", {wr_addr, wr_dat}); end
        vectors++; if (sda_o !== 1'b0) begin miscompares++; $display("FAIL reset_sda_o got %b exp 0", sda_o); end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        $display("reset: checked idle outputs");
    endtask

    task automatic test_write_basic();
        logic ok, bad;
        wr_buf[0] = 8'hA5; wr_buf[1] = 8'h5A;
        do_write(8'h03, 2, ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL basic_acks got %b exp 1", ok); end
        vectors++; if (regs_flat !== model_flat()) begin miscompares++; $display("FAIL basic_regs got %h exp %h", regs_flat, model_flat()); end
        bad = (got_q.size() != exp_q.size());
        if (!bad) foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) bad = 1'b1;
        vectors++; if (bad) begin miscompares++; $display("FAIL basic_strobes got %0d entries exp %0d", got_q.size(), exp_q.size()); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy_after_stop got %b exp 0", busy); end
        got_q.delete(); exp_q.delete();
        $display("write ptr=03 data=A5,5A: regs3=%h regs4=%h", regs_flat[31:24], regs_flat[39:32]);
    endtask

    task automatic test_read_rs();
        logic a0, a1, a2;
        logic [7:0] d0, d1, d2;
        i2c_start();
        wr_byte(8'hC0, -1, a0); wr_byte(8'h02, -1, a1);
        i2c_start();
        wr_byte(8'hC1, -1, a2);
        vectors++; if ({a0, a1, a2} !== 3'b000) begin miscompares++; $display("FAIL rs_acks got %b exp 000", {a0, a1, a2}); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rs_busy_addressed got %b exp 1", busy); end
        rd_byte(1'b0, d0); rd_byte(1'b0, d1); rd_byte(1'b1, d2);
        vectors++; if ({d0, d1, d2} !== {model_regs[2], model_regs[3], model_regs[4]}) begin
            miscompares++; $display("FAIL rs_data got %h exp %h", {d0, d1, d2}, {model_regs[2], model_regs[3], model_regs[4]}); end
        repeat (4) @(negedge clk);
        vectors++; if (sda_oen !== 1'b1) begin miscompares++; $display("FAIL rs_release_after_nack got %b exp 1", sda_oen); end
        i2c_stop();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rs_busy_after_stop got %b exp 0", busy); end
        model_ptr = 4'd4;
        $display("read ptr=02 x3: %h %h %h", d0, d1, d2);
    endtask

    task automatic test_bad_addr();
        logic a, b;
        i2c_start();
        wr_byte(8'hC2, -1, a);
        vectors++; if (a !== 1'b1) begin miscompares++; $display("FAIL badaddr_ack got %b exp 1", a); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL badaddr_busy got %b exp 0", busy); end
        wr_byte(8'h01, -1, b);
        wr_byte(8'h77, -1, b);
        i2c_stop();
        vectors++; if (regs_flat !== model_flat()) begin miscompares++; $display("FAIL badaddr_regs got %h exp %h", regs_flat, model_flat()); end
        vectors++; if (got_q.size() != 0) begin miscompares++; $display("FAIL badaddr_strobes got %0d exp 0", got_q.size()); end
        got_q.delete();
        $display("address 0x61: ack bit %b", a);
    endtask

    task automatic test_wrap();
        logic ok, bad;
        wr_buf[0] = 8'h11; wr_buf[1] = 8'h22;
        do_write(8'h0F, 2, ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL wrap_acks got %b exp 1", ok); end
        vectors++; if ({regs_flat[127:120], regs_flat[7:0]} !== 16'h1122) begin
            miscompares++; $display("FAIL wrap_regs got %h exp 1122", {regs_flat[127:120], regs_flat[7:0]}); end
        bad = (got_q.size() != exp_q.size());
        if (!bad) foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) bad = 1'b1;
        vectors++; if (bad) begin miscompares++; $display("FAIL wrap_strobes got %0d entries exp %0d", got_q.size(), exp_q.size()); end
        got_q.delete(); exp_q.delete();
        $display("write ptr=0F data=11,22: reg15=%h reg0=%h", regs_flat[127:120], regs_flat[7:0]);
    endtask

    task automatic test_stop_mid();
        logic a0, a1, ok, bad;
        logic [7:0] d;
        d = 8'h96;
        i2c_start();
        wr_byte(8'hC0, -1, a0); wr_byte(8'h07, -1, a1);
        model_ptr = 4'd7;
        for (int i = 7; i >= 4; i--) begin
            sda_m = d[i]; wq(); scl = 1'b1; wq(); wq(); scl = 1'b0; wq();
        end
        i2c_stop();
        vectors++; if (got_q.size() != 0) begin miscompares++; $display("FAIL stopmid_strobes got %0d exp 0", got_q.size()); end
        vectors++; if (regs_flat !== model_flat()) begin miscompares++; $display("FAIL stopmid_regs got %h exp %h", regs_flat, model_flat()); end
        got_q.delete();
        wr_buf[0] = 8'h3C;
        do_write(8'h07, 1, ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL stopmid_next_acks got %b exp 1", ok); end
        vectors++; if (regs_flat !== model_flat()) begin miscompares++; $display("FAIL stopmid_next_regs got %h exp %h", regs_flat, model_flat()); end
        bad = (got_q.size() != exp_q.size());
        if (!bad) foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) bad = 1'b1;
        vectors++; if (bad) begin miscompares++; $display("FAIL stopmid_next_strobes got %0d entries exp %0d", got_q.size(), exp_q.size()); end
        got_q.delete(); exp_q.delete();
        $display("stop after 4 bits then write reg7=%h", regs_flat[63:56]);
    endtask

    task automatic test_random();
        logic ok, bad;
        int kind, n;
        logic [7:0] p;
        for (int it = 0; it < 16; it++) begin
            kind = $urandom_range(0, 2);
            n = $urandom_range(1, 4);
            p = 8'($urandom);
            if (kind == 0) begin
                for (int k = 0; k < 4; k++) wr_buf[k] = 8'($urandom);
                do_write(p, n, ok);
                bad = (got_q.size() != exp_q.size());
                if (!bad) foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) bad = 1'b1;
                vectors++; if (bad) begin miscompares++; $display("FAIL rand_strobes it=%0d got %0d entries exp %0d", it, got_q.size(), exp_q.size()); end
                got_q.delete(); exp_q.delete();
            end else begin
                do_read(kind == 1, p, n, ok);
                for (int k = 0; k < n; k++) begin
                    vectors++; if (rd_got[k] !== rd_exp[k]) begin miscompares++; $display("FAIL rand_read it=%0d byte=%0d got %h exp %h", it, k, rd_got[k], rd_exp[k]); end
                end
            end
            vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL rand_acks it=%0d got %b exp 1", it, ok); end
            vectors++; if (regs_flat !== model_flat()) begin miscompares++; $display("FAIL rand_regs it=%0d got %h exp %h", it, regs_flat, model_flat()); end
            $display("random txn %0d: kind=%0d ptr=%h len=%0d", it, kind, p, n);
        end
    endtask

    task automatic test_reset_mid_read();
        logic ok, a0, a1, a2;
        wr_buf[0] = 8'h00;
        do_write(8'h09, 1, ok);
        got_q.delete(); exp_q.delete();
        i2c_start();
        wr_byte(8'hC0, -1, a0); wr_byte(8'h09, -1, a1);
        i2c_start();
        wr_byte(8'hC1, -1, a2);
        repeat (2) @(negedge clk);
        vectors++; if (sda_oen !== 1'b0) begin miscompares++; $display("FAIL rstmid_driving got %b exp 0", sda_oen); end
        rst_n = 1'b0;
        #1;
        vectors++; if (sda_oen !== 1'b1) begin miscompares++; $display("FAIL rstmid_release got %b exp 1", sda_oen); end
        vectors++; if (regs_flat !== 128'd0) begin miscompares++; $display("FAIL rstmid_regs got %h exp 0", regs_flat); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy got %b exp 0", busy); end
        scl = 1'b1; sda_m = 1'b1;
        repeat (6) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 16; i++) model_regs[i] = 8'h00;
        model_ptr = 4'd0;
        got_q.delete(); exp_q.delete();
        wr_buf[0] = 8'hC3;
        do_write(8'h01, 1, ok);
        do_read(1'b1, 8'h01, 1, ok);
        vectors++; if (rd_got[0] !== rd_exp[0]) begin miscompares++; $display("FAIL rstmid_after_read got %h exp %h", rd_got[0], rd_exp[0]); end
        got_q.delete(); exp_q.delete();
        $display("reset during read: sda_oen=%b after reset", sda_oen);
    endtask

`ifdef GLITC_I2C_TARGET_GLITCH_FILTER_EN
    task automatic test_glitch();
        logic a0, a1, a2;
        i2c_start();
        wr_byte(8'hC0, -1, a0); wr_byte(8'h05, -1, a1);
        model_ptr = 4'd5;
        wr_byte(8'h3C, 7, a2);
        vectors++; if ({a0, a1, a2} !== 3'b000) begin miscompares++; $display("FAIL glitch_acks got %b exp 000", {a0, a1, a2}); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL glitch_busy got %b exp 1", busy); end
        i2c_stop();
        model_regs[5] = 8'h3C;
        model_ptr = 4'd6;
        vectors++; if (regs_flat !== model_flat()) begin miscompares++; $display("FAIL glitch_regs got %h exp %h", regs_flat, model_flat()); end
        got_q.delete();
        $display("glitch on SDA while SCL high: reg5=%h", regs_flat[47:40]);
    endtask
`endif

    initial begin
        for (int i = 0; i < 16; i++) model_regs[i] = 8'h00;
        model_ptr = 4'd0;
        test_reset();
        test_write_basic();
        test_read_rs();
        test_bad_addr();
        test_wrap();
        test_stop_mid();
        test_random();
        test_reset_mid_read();
`ifdef GLITC_I2C_TARGET_GLITCH_FILTER_EN
        test_glitch();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/glitc_i2c_target.md
Name: glitc_i2c_target

Overview:
- I2C target (responder) for the GLITC I2C bus.
- Sits at the far end from the I2C master that drives the DAC and attenuator updates.
- Used two ways:
  - Synthesizable register-bank target, so an external controller can configure GLITC over I2C.
  - Bench/board-level responder that stands in for a Vped DAC or attenuator.
- Holds a small 8-bit register file with an auto-incrementing pointer. Each completed I2C write is reported to local logic as a single-cycle strobe.

Parameters:
- DEV_ADDR, 7'h60, 7-bit target address matched in the address byte.
- NUM_REGS, 16, register count (power of two, 2..256).
- PTR_W, 4, pointer width; equals log2(NUM_REGS).
- SYNC_STAGES, 2, synchronizer depth on scl_i/sda_i (minimum 2).

Ports:
- user_clk_i  in  1  system clock; at least 8x the SCL rate.
- user_rst_n_i  in  1  asynchronous active-low reset.
- scl_i  in  1  SCL pad input.
- sda_i  in  1  SDA pad input.
- sda_o  out  1  SDA pad output; constant 0.
- sda_oen_o  out  1  SDA output enable, active-low. 0 pulls the line low; 1 releases it.
- regs_o  out  8*NUM_REGS  flattened register file; byte n is at bits [8n+7:8n].
- wr_stb_o  out  1  one-cycle pulse for each data byte written by the master.
- wr_addr_o  out  PTR_W  register index of that write.
- wr_dat_o  out  8  byte written.
- busy_o  out  1  high while addressed; from address match until STOP or repeated START.

Behaviour:
- Reset values, asynchronous, active while user_rst_n_i=0:
  - sda_oen_o=1 and wr_stb_o=0.
  - wr_addr_o=0, wr_dat_o=0, busy_o=0.
  - All registers 0, pointer 0, state IDLE.
- Input path:
  - scl_i and sda_i each pass through SYNC_STAGES flops.
  - Edges are detected by comparing the last two synchronized samples.
- Bus conditions:
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Both are recognized in any state.
  - START always enters ADDR with bit counter 0.
  - STOP always enters IDLE and releases SDA.
- Bit sampling and driving:
  - SDA is sampled on the SCL rising edge.
  - The target changes sda_oen_o only on the cycle after an SCL falling edge, never while SCL is high.
- State machine:
  - IDLE: waits for START.
  - ADDR: shifts in 8 bits, MSB first.
    - Match (bits[7:1]==DEV_ADDR): go to ACK_ADDR and latch the R/W bit.
    - No match: go to IDLE and do not drive SDA.
  - ACK_ADDR: drive SDA low for one SCL period.
    - R/W=0: go to WR_PTR.
    - R/W=1: go to RD_BYTE and load the shift register with reg[ptr].
  - WR_PTR: shift in 8 bits; ptr <= byte[PTR_W-1:0], upper bits ignored; ACK; go to WR_DATA.
  - WR_DATA: shift in 8 bits, then ACK.
    - On the ACK falling edge: reg[ptr] <= byte, wr_stb_o=1 for one cycle with wr_addr_o=ptr and wr_dat_o=byte, then ptr increments.
    - Stay in WR_DATA for further bytes.
  - RD_BYTE: drive bits MSB first, each after an SCL falling edge (drive low for 0, release for 1); go to RD_ACK.
  - RD_ACK: release SDA and sample the master's ACK on the SCL rising edge.
    - ACK (0): ptr increments; load reg[ptr]; go to RD_BYTE.
    - NACK (1): go to IDLE.
- Pointer arithmetic:
  - Increments modulo NUM_REGS; NUM_REGS-1 wraps to 0.
  - Reads increment only after an ACKed byte.
  - Writes increment after every data byte.
- Boundary conditions:
  - Repeated START after WR_PTR keeps ptr, which gives the standard register-read sequence.
  - STOP mid-byte discards the partial byte: no strobe, no register update.
  - Reset mid-transfer releases SDA immediately.
  - START and STOP in the same cycle cannot occur; if a synchronizer glitch produces both, STOP wins.
- Clock stretching: none. SCL is never driven.

Optional Feature:
- Macro: GLITC_I2C_TARGET_GLITCH_FILTER_EN.
- Defined: each synchronized line passes through a 3-sample stability filter. The filtered value changes only after 3 consecutive equal samples, rejecting pulses of 2 clocks or less. Adds 2 cycles of latency; the minimum clock ratio rises to 12x SCL.
- Undefined: raw synchronized samples are used, with no added latency.

Decomposition:
- Package glitc_i2c_pkg holds:
  - State enum (IDLE, ADDR, ACK_ADDR, WR_PTR, WR_DATA, RD_BYTE, RD_ACK).
  - Constant I2C_BYTE_BITS=8.
  - Constant for the R/W bit position.
- Sub-module i2c_line_cond handles one line: synchronizer, optional filter, and rise/fall outputs. It is instantiated twice, once for SCL and once for SDA.

Test Plan:
- Write pointer 0x03 then data 0xA5, 0x5A to DEV_ADDR=0x60 -> two ACKs on data; reg3=0xA5, reg4=0x5A; wr_stb_o pulses twice with (3,A5) then (4,5A).
- Write pointer 0x02, repeated START, read 3 bytes ACK/ACK/NACK -> returns reg2, reg3, reg4; target releases SDA after NACK; busy_o falls on STOP.
- Address 0x61 write -> no ACK (SDA stays high in the 9th clock); no register change; busy_o stays 0.
- Write pointer 0x0F, data 0x11, 0x22 -> reg15=0x11, reg0=0x22 (wrap).
- STOP after 4 bits of a data byte -> no wr_stb_o, register unchanged; next transaction works normally.
- Assert user_rst_n_i mid-read while driving SDA low -> sda_oen_o=1 in the same cycle; all regs 0. With the filter macro defined, a 1-cycle SDA glitch while SCL is high produces no START/STOP.
